spi_flash_read_sequencer: RTL and testbench
===========================================

Name: spi_flash_read_sequencer

Overview:
- Hardware sequencer that runs a complete SPI flash READ (0x03) transaction on the flash SPI byte engine, with no per-byte CPU register writes.
- Sends the command and a 24-bit address, then streams N data bytes out through a valid/ready port.
- Sits between the SPI CSR block and the flash byte engine. It takes the engine's enable, write data and chip select while oOwn=1.

Parameters:
pDivClk, 16, width of the clock divider passed through to the byte engine
pLenWidth, 16, width of the transfer byte count
pCsGuard, 4, idle cycles between a CS edge and the next engine action (setup and hold)
pCmdRead, 8'h03, command byte sent first

Ports:
iSCLK  in  1  system clock
iSRST  in  1  reset, asynchronous, active-low
iStart  in  1  one-cycle start request; sampled only in IDLE
iAdrs  in  24  flash byte address; captured on an accepted start
iLen  in  pLenWidth  number of data bytes; captured on an accepted start
iAbort  in  1  request to end the transaction early
iDiv  in  pDivClk  SCLK divider; forwarded to oSpiDiv
oBusy  out  1  high from the accepted start until the done pulse
oDone  out  1  one-cycle completion pulse
oAborted  out  1  valid with oDone; 1 = ended by iAbort
oRdData  out  8  received data byte
oRdValid  out  1  oRdData valid; held until iRdReady
iRdReady  in  1  downstream accepts the byte
oOwn  out  1  sequencer owns the engine (drives the SPI-mode / IO select)
oSpiEn  out  1  byte-engine start (level)
oSpiDiv  out  pDivClk  registered copy of iDiv
oSpiWd  out  8  byte to transmit
oSpiCs  out  1  flash chip select, active-low
iSpiIntr  in  1  engine one-cycle pulse: byte finished
iSpiRd  in  8  engine received byte; valid in the iSpiIntr cycle

Behaviour:
- Reset (asynchronous, iSRST=0):
  - State = IDLE.
  - oSpiCs=1.
  - oSpiEn, oBusy, oDone, oAborted, oRdValid, oOwn = 0.
  - oRdData=0, oSpiWd=0, oSpiDiv = all ones.
  - Reset asserted mid-transaction forces all of the above immediately; any engine byte in flight is abandoned.
- All outputs are registered.
- States: IDLE, CS_SETUP, CMD, ADR2, ADR1, ADR0, DATA, DATA_OUT, CS_HOLD, DONE.
- IDLE:
  - iStart=1 captures iAdrs and iLen, sets oBusy=1 and oOwn=1, then goes to CS_SETUP.
  - oSpiCs falls in the cycle after the start cycle (call it t+1).
- iStart while oBusy=1 is ignored; no queueing.
- CS_SETUP: count pCsGuard cycles, then go to CMD.
- Byte rule, used by CMD, ADRx and DATA:
  - Load oSpiWd and set oSpiEn=1.
  - Hold both until iSpiIntr.
  - In the iSpiIntr cycle, clear oSpiEn and advance.
  - oSpiEn must be 0 for at least one cycle between bytes.
- Byte order: CMD sends pCmdRead. ADR2, ADR1, ADR0 send address bits [23:16], [15:8], [7:0].
- After ADR0:
  - If the remaining count is 0, go to CS_HOLD (address-only transaction).
  - Otherwise go to DATA.
- DATA:
  - Transmit 0x00.
  - On iSpiIntr: latch iSpiRd into oRdData, set oRdValid=1, decrement the remaining count, go to DATA_OUT.
- DATA_OUT:
  - Wait until oRdValid && iRdReady. Clear oRdValid in the next cycle.
  - Then go to DATA if the count is nonzero, otherwise CS_HOLD.
  - No new byte is issued while a byte is unaccepted; iRdReady=0 stalls indefinitely with CS held low.
- CS_HOLD: count pCsGuard cycles with oSpiCs=0, then drive oSpiCs=1 and go to DONE.
- DONE:
  - Stay pCsGuard cycles with CS high. This guarantees the deselect time before the next start.
  - Then pulse oDone for one cycle; clear oBusy and oOwn in the same cycle; return to IDLE.
- Abort:
  - iAbort is latched as a sticky flag while oBusy=1.
  - If a byte is in flight (oSpiEn=1), finish that byte first. An abort received during DATA still presents its byte on oRdValid and waits for the handshake.
  - At the next byte boundary, go to CS_HOLD.
  - oAborted=1 with oDone. The flag clears on return to IDLE.
- iAbort and iStart in the same IDLE cycle: start wins; the abort is ignored.
- Count arithmetic: unsigned pLenWidth bits; maximum 2^pLenWidth−1 bytes. There is no address wrap handling; the flash device handles wrap.
- Latency, ideal (engine N cycles per byte, iRdReady=1): first oRdValid at t+1+pCsGuard+5 byte slots.

Decomposition:
- Shared package:
  - state encoding localparams;
  - flash command constants (READ 0x03, plus future FAST_READ 0x0B and RDSR 0x05);
  - the pCsGuard default.
- One sub-module, spi_guard_timer: a loadable down-counter with a zero flag, reused by CS_SETUP, CS_HOLD and DONE.
- The FSM, address/length registers and handshake logic stay in the top module.

Test Plan:
- Reset release; iStart, iAdrs=24'h012345, iLen=2, engine model 8 cycles per byte, returning 8'hA5 then 8'h5A, iRdReady=1 -> oSpiWd sequence 03,01,23,45,00,00; oRdData A5 then 5A; oDone once; oAborted=0; CS low for the whole transaction.
- iLen=0, iAdrs=24'hFFFFFF -> four bytes (03,FF,FF,FF), no oRdValid, oDone pulse.
- iLen=3 with iRdReady held low for 20 cycles after the first byte -> oSpiEn stays 0 and CS stays low during the stall; the data sequence completes after release.
- iAbort asserted during the second data byte of iLen=100 -> that byte completes and is delivered; CS rises after pCsGuard; oDone with oAborted=1; 2 bytes delivered in total.
- iStart pulsed while busy, and iSRST pulled low mid-ADR1 -> the extra start is ignored; on reset oSpiCs=1, oSpiEn=0, oBusy=0 asynchronously.
- Back-to-back starts issued as soon as oDone is seen -> at least pCsGuard cycles of CS high between transactions.

Source files
------------

// File: rtl/spi_flash_read_sequencer_pkg.sv
// Shared constants for the SPI flash read sequencer: FSM state encodings,
// flash command opcodes and the default chip-select guard length.
package spi_flash_read_sequencer_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] ST_CS_SETUP = 4'd1;
    localparam logic [STATE_W-1:0] ST_CMD      = 4'd2;
    localparam logic [STATE_W-1:0] ST_ADR2     = 4'd3;
    localparam logic [STATE_W-1:0] ST_ADR1     = 4'd4;
    localparam logic [STATE_W-1:0] ST_ADR0     = 4'd5;
    localparam logic [STATE_W-1:0] ST_DATA     = 4'd6;
    localparam logic [STATE_W-1:0] ST_DATA_OUT = 4'd7;
    localparam logic [STATE_W-1:0] ST_CS_HOLD  = 4'd8;
    localparam logic [STATE_W-1:0] ST_DONE     = 4'd9;

    // FAST_READ and RDSR are reserved for later sequencer variants.
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_RDSR      = 8'h05;

    localparam int CS_GUARD_DEFAULT = 4;
    localparam int GUARD_WIDTH      = 8;

    function automatic logic isByteState(input logic [STATE_W-1:0] state);
        return (state == ST_CMD)  || (state == ST_ADR2) || (state == ST_ADR1) ||
               (state == ST_ADR0) || (state == ST_DATA);
    endfunction

endpackage

// File: rtl/spi_guard_timer.sv
// Loadable down-counter with a zero flag; times the CS setup, hold and
// deselect intervals of the read sequencer.
module spi_guard_timer #(
    parameter int pWidth = 8
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iLoad,
    input  logic [pWidth-1:0] iLoadVal,
    output logic              oZero
);

    logic [pWidth-1:0] r_count;

    // Counter parks at zero so the flag stays valid until the next load.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_count <= '0;
        end else if (iLoad) begin
            r_count <= iLoadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - pWidth'(1);
        end
    end

    assign oZero = (r_count == '0);

endmodule

// File: rtl/spi_flash_read_sequencer.sv
// Runs a complete SPI flash READ transaction (command, 24-bit address, N data
// bytes) on the byte engine and streams the received bytes over valid/ready.
module spi_flash_read_sequencer
    import spi_flash_read_sequencer_pkg::*;
#(
    parameter int         pDivClk   = 16,
    parameter int         pLenWidth = 16,
    parameter int         pCsGuard  = CS_GUARD_DEFAULT,
    parameter logic [7:0] pCmdRead  = CMD_READ
) (
    input  logic                 iSCLK,
    input  logic                 iSRST,
    input  logic                 iStart,
    input  logic [23:0]          iAdrs,
    input  logic [pLenWidth-1:0] iLen,
    input  logic                 iAbort,
    input  logic [pDivClk-1:0]   iDiv,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oAborted,
    output logic [7:0]           oRdData,
    output logic                 oRdValid,
    input  logic                 iRdReady,
    output logic                 oOwn,
    output logic                 oSpiEn,
    output logic [pDivClk-1:0]   oSpiDiv,
    output logic [7:0]           oSpiWd,
    output logic                 oSpiCs,
    input  logic                 iSpiIntr,
    input  logic [7:0]           iSpiRd
);

    localparam logic [GUARD_WIDTH-1:0] cGuardLoad = GUARD_WIDTH'(pCsGuard - 1);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_next;
    logic [23:0]          r_adrs;
    logic [pLenWidth-1:0] r_len;
    logic                 r_abort;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_aborted;
    logic [7:0]           r_rdData;
    logic                 r_rdValid;
    logic                 r_own;
    logic                 r_spiEn;
    logic [pDivClk-1:0]   r_spiDiv;
    logic [7:0]           r_spiWd;
    logic                 r_spiCs;
    logic [7:0]           w_txByte;
    logic                 w_timerLoad;
    logic                 w_guardZero;

    spi_guard_timer #(
        .pWidth(GUARD_WIDTH)
    ) u_guard (
        .iClk    (iSCLK),
        .iRstN   (iSRST),
        .iLoad   (w_timerLoad),
        .iLoadVal(cGuardLoad),
        .oZero   (w_guardZero)
    );

    always_comb begin
        w_txByte = 8'h00;
        case (r_state)
            ST_CMD:  w_txByte = pCmdRead;
            ST_ADR2: w_txByte = r_adrs[23:16];
            ST_ADR1: w_txByte = r_adrs[15:8];
            ST_ADR0: w_txByte = r_adrs[7:0];
            default: w_txByte = 8'h00;
        endcase
    end

    // Byte states advance only on the engine's completion pulse; a pending
    // abort is honoured at the idle gap before the next byte would be issued.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (iStart) w_next = ST_CS_SETUP;
            ST_CS_SETUP: if (w_guardZero) w_next = ST_CMD;
            ST_CMD, ST_ADR2, ST_ADR1, ST_ADR0, ST_DATA: begin
                if (r_spiEn) begin
                    if (iSpiIntr) begin
                        case (r_state)
                            ST_CMD:  w_next = r_abort ? ST_CS_HOLD : ST_ADR2;
                            ST_ADR2: w_next = r_abort ? ST_CS_HOLD : ST_ADR1;
                            ST_ADR1: w_next = r_abort ? ST_CS_HOLD : ST_ADR0;
                            ST_ADR0: w_next = (r_abort || r_len == '0) ? ST_CS_HOLD : ST_DATA;
                            default: w_next = ST_DATA_OUT;
                        endcase
                    end
                end else if (r_abort) begin
                    w_next = ST_CS_HOLD;
                end
            end
            ST_DATA_OUT: begin
                if (r_rdValid && iRdReady) begin
                    w_next = (r_abort || r_len == '0) ? ST_CS_HOLD : ST_DATA;
                end
            end
            ST_CS_HOLD:  if (w_guardZero) w_next = ST_DONE;
            ST_DONE:     if (w_guardZero) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    assign w_timerLoad = (w_next != r_state) &&
                         ((w_next == ST_CS_SETUP) || (w_next == ST_CS_HOLD) || (w_next == ST_DONE));

    always_ff @(posedge iSCLK or negedge iSRST) begin
        if (!iSRST) begin
            r_state   <= ST_IDLE;
            r_adrs    <= '0;
            r_len     <= '0;
            r_abort   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_rdData  <= 8'h00;
            r_rdValid <= 1'b0;
            r_own     <= 1'b0;
            r_spiEn   <= 1'b0;
            r_spiDiv  <= '1;
            r_spiWd   <= 8'h00;
            r_spiCs   <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_spiDiv  <= iDiv;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            // Abort only matters before the closing CS hold; later it would be misreported.
            if (r_busy && iAbort && r_state != ST_CS_HOLD && r_state != ST_DONE) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_adrs  <= iAdrs;
                        r_len   <= iLen;
                        r_busy  <= 1'b1;
                        r_own   <= 1'b1;
                        r_spiCs <= 1'b0;
                    end
                end
                ST_CMD, ST_ADR2, ST_ADR1, ST_ADR0, ST_DATA: begin
                    if (r_spiEn) begin
                        if (iSpiIntr) begin
                            r_spiEn <= 1'b0;
                            if (r_state == ST_DATA) begin
                                r_rdData  <= iSpiRd;
                                r_rdValid <= 1'b1;
                                r_len     <= r_len - pLenWidth'(1);
                            end
                        end
                    end else if (w_next == r_state) begin
                        r_spiEn <= 1'b1;
                        r_spiWd <= w_txByte;
                    end
                end
                ST_DATA_OUT: begin
                    if (r_rdValid && iRdReady) begin
                        r_rdValid <= 1'b0;
                    end
                end
                ST_CS_HOLD: begin
                    if (w_guardZero) begin
                        r_spiCs <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_guardZero) begin
                        r_done    <= 1'b1;
                        r_aborted <= r_abort;
                        r_abort   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_own     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy    = r_busy;
    assign oDone    = r_done;
    assign oAborted = r_aborted;
    assign oRdData  = r_rdData;
    assign oRdValid = r_rdValid;
    assign oOwn     = r_own;
    assign oSpiEn   = r_spiEn;
    assign oSpiDiv  = r_spiDiv;
    assign oSpiWd   = r_spiWd;
    assign oSpiCs   = r_spiCs;

endmodule

// File: tb/tb_spi_flash_read_sequencer.sv
// Directed bench for spi_flash_read_sequencer: a transaction table plus
// hand-written sequences, with an 8-cycle byte-engine model.
module tb_spi_flash_read_sequencer;

    localparam int GUARD      = 4;
    localparam int ENG_CYCLES = 8;
    localparam int TIMEOUT    = 5000;

    typedef struct {
        string       name;
        logic [23:0] adrs;
        logic [15:0] len;
        int          stall;
        int          abortByte;
        int          expWd;
        int          expRd;
        int          expAborted;
    } vec_t;

    logic        iSCLK    = 1'b0;
    logic        iSRST    = 1'b1;
    logic        iStart   = 1'b0;
    logic [23:0] iAdrs    = '0;
    logic [15:0] iLen     = '0;
    logic        iAbort   = 1'b0;
    logic [15:0] iDiv     = 16'h0004;
    logic        iRdReady = 1'b1;
    logic        iSpiIntr = 1'b0;
    logic [7:0]  iSpiRd   = 8'h00;
    logic        oBusy, oDone, oAborted, oRdValid, oOwn, oSpiEn, oSpiCs;
    logic [7:0]  oRdData, oSpiWd;
    logic [15:0] oSpiDiv;

    int total = 0;
    int bad   = 0;

    logic [7:0] wdLog[$];
    logic [7:0] rdLog[$];
    int engCnt        = 0;
    int byteIdx       = 0;
    int doneCnt       = 0;
    int lastAborted   = 0;
    int guardErr      = 0;
    int csRise        = 0;
    int highRun       = 0;
    int lastHighGap   = 0;
    int idleRun       = 0;
    bit firstEnPending = 1'b0;
    logic prevCs      = 1'b1;

    vec_t vecs[4];

    spi_flash_read_sequencer #(
        .pDivClk  (16),
        .pLenWidth(16),
        .pCsGuard (GUARD),
        .pCmdRead (8'h03)
    ) dut (
        .iSCLK   (iSCLK),
        .iSRST   (iSRST),
        .iStart  (iStart),
        .iAdrs   (iAdrs),
        .iLen    (iLen),
        .iAbort  (iAbort),
        .iDiv    (iDiv),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oAborted(oAborted),
        .oRdData (oRdData),
        .oRdValid(oRdValid),
        .iRdReady(iRdReady),
        .oOwn    (oOwn),
        .oSpiEn  (oSpiEn),
        .oSpiDiv (oSpiDiv),
        .oSpiWd  (oSpiWd),
        .oSpiCs  (oSpiCs),
        .iSpiIntr(iSpiIntr),
        .iSpiRd  (iSpiRd)
    );

    always #5 iSCLK = ~iSCLK;

    function automatic logic [7:0] rdVal(input int k);
        if (k == 0) return 8'hA5;
        if (k == 1) return 8'h5A;
        return 8'(8'h30 + k);
    endfunction

    function automatic logic [7:0] expWdByte(input logic [23:0] a, input int i);
        if (i == 0) return 8'h03;
        if (i == 1) return a[23:16];
        if (i == 2) return a[15:8];
        if (i == 3) return a[7:0];
        return 8'h00;
    endfunction

    // Engine model: ENG_CYCLES cycles of oSpiEn per byte, then a one-cycle done pulse.
    always @(negedge iSCLK) begin
        if (!iSRST) begin
            engCnt   = 0;
            iSpiIntr = 1'b0;
            byteIdx  = 0;
        end else begin
            if (oSpiCs) byteIdx = 0;
            if (iSpiIntr) begin
                iSpiIntr = 1'b0;
                engCnt   = 0;
            end else if (oSpiEn) begin
                engCnt++;
                if (engCnt == ENG_CYCLES) begin
                    iSpiIntr = 1'b1;
                    iSpiRd   = (byteIdx >= 4) ? rdVal(byteIdx - 4) : 8'hEE;
                    wdLog.push_back(oSpiWd);
                    byteIdx++;
                end
            end
        end
    end

    // Bus monitor: delivered bytes, done pulses and CS guard intervals.
    always @(negedge iSCLK) begin
        if (!iSRST) begin
            prevCs         = 1'b1;
            highRun        = 0;
            idleRun        = 0;
            firstEnPending = 1'b0;
        end else begin
            if (oRdValid && iRdReady) rdLog.push_back(oRdData);
            if (oDone) begin
                doneCnt++;
                lastAborted = int'(oAborted);
            end
            if (oSpiEn && oSpiCs) guardErr++;
            if (oSpiCs) begin
                if (!prevCs) begin
                    csRise++;
                    if (idleRun < GUARD) guardErr++;
                end
                highRun++;
            end else begin
                if (prevCs) begin
                    lastHighGap    = highRun;
                    highRun        = 0;
                    idleRun        = 0;
                    firstEnPending = 1'b1;
                end
                if (oSpiEn) begin
                    if (firstEnPending && idleRun < GUARD) guardErr++;
                    firstEnPending = 1'b0;
                    idleRun        = 0;
                end else if (!oRdValid) begin
                    idleRun++;
                end else begin
                    idleRun = 0;
                end
            end
            prevCs = oSpiCs;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge iSCLK);
        #1;
    endtask

    task automatic pulseStart(input logic [23:0] adrs, input logic [15:0] len);
        iAdrs  = adrs;
        iLen   = len;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        iAdrs  = '0;
        iLen   = '0;
    endtask

    task automatic applyStimulus(input vec_t v, output int d0, output int g0, output int r0);
        int cyc;
        int stallBad;
        wdLog.delete();
        rdLog.delete();
        d0 = doneCnt;
        g0 = guardErr;
        r0 = csRise;
        iRdReady = (v.stall == 0);
        pulseStart(v.adrs, v.len);
        if (v.stall > 0) begin
            for (cyc = 0; cyc < TIMEOUT && !oRdValid; cyc++) tick();
            checkOutput({v.name, "_valid_timeout"}, (cyc >= TIMEOUT), 0);
            stallBad = 0;
            repeat (v.stall) begin
                tick();
                if (oSpiEn || oSpiCs || !oRdValid) stallBad++;
            end
            checkOutput({v.name, "_stall_hold"}, stallBad, 0);
            iRdReady = 1'b1;
        end
        if (v.abortByte >= 0) begin
            for (cyc = 0; cyc < TIMEOUT && !(byteIdx == v.abortByte && oSpiEn); cyc++) tick();
            checkOutput({v.name, "_abort_timeout"}, (cyc >= TIMEOUT), 0);
            iAbort = 1'b1;
            tick();
            iAbort = 1'b0;
        end
        for (cyc = 0; cyc < TIMEOUT && doneCnt == d0; cyc++) tick();
        checkOutput({v.name, "_done_timeout"}, (cyc >= TIMEOUT), 0);
        repeat (3) tick();
    endtask

    task automatic checkVector(input vec_t v, input int d0, input int g0, input int r0);
        checkOutput({v.name, "_wd_count"}, wdLog.size(), v.expWd);
        for (int i = 0; i < wdLog.size() && i < v.expWd; i++)
            checkOutput($sformatf("%s_wd%0d", v.name, i), wdLog[i], expWdByte(v.adrs, i));
        checkOutput({v.name, "_rd_count"}, rdLog.size(), v.expRd);
        for (int i = 0; i < rdLog.size() && i < v.expRd; i++)
            checkOutput($sformatf("%s_rd%0d", v.name, i), rdLog[i], rdVal(i));
        checkOutput({v.name, "_done_once"}, doneCnt - d0, 1);
        checkOutput({v.name, "_aborted"}, lastAborted, v.expAborted);
        checkOutput({v.name, "_guard"}, guardErr - g0, 0);
        checkOutput({v.name, "_cs_one_rise"}, csRise - r0, 1);
        checkOutput({v.name, "_busy_low"}, oBusy, 0);
        checkOutput({v.name, "_own_low"}, oOwn, 0);
    endtask

    initial begin
        int d0, g0, r0, cyc;

        vecs[0] = '{"basic",   24'h012345, 16'd2,   0,  -1, 6, 2, 0};
        vecs[1] = '{"adronly", 24'hFFFFFF, 16'd0,   0,  -1, 4, 0, 0};
        vecs[2] = '{"stall",   24'h000100, 16'd3,   20, -1, 7, 3, 0};
        vecs[3] = '{"abort",   24'h0A0B0C, 16'd100, 0,   5, 6, 2, 1};

        #1 iSRST = 1'b0;
        #2;
        checkOutput("rst_cs",     oSpiCs,   1);
        checkOutput("rst_en",     oSpiEn,   0);
        checkOutput("rst_busy",   oBusy,    0);
        checkOutput("rst_done",   oDone,    0);
        checkOutput("rst_abt",    oAborted, 0);
        checkOutput("rst_valid",  oRdValid, 0);
        checkOutput("rst_own",    oOwn,     0);
        checkOutput("rst_rddata", oRdData,  8'h00);
        checkOutput("rst_wd",     oSpiWd,   8'h00);
        checkOutput("rst_div",    oSpiDiv,  16'hFFFF);
        tick();
        tick();
        iSRST = 1'b1;
        repeat (3) tick();
        checkOutput("div_copy", oSpiDiv, 16'h0004);

        for (int n = 0; n < 4; n++) begin
            $display("[TB] vector %s", vecs[n].name);
            applyStimulus(vecs[n], d0, g0, r0);
            checkVector(vecs[n], d0, g0, r0);
        end

        // Start while busy is ignored; async reset lands mid-ADR1.
        $display("[TB] busy start and mid-transaction reset");
        wdLog.delete();
        pulseStart(24'hABCDEF, 16'd100);
        for (cyc = 0; cyc < TIMEOUT && !(byteIdx == 0 && oSpiEn); cyc++) tick();
        checkOutput("busy_cmd_timeout", (cyc >= TIMEOUT), 0);
        pulseStart(24'h111111, 16'd0);
        for (cyc = 0; cyc < TIMEOUT && !(byteIdx == 2 && oSpiEn); cyc++) tick();
        checkOutput("busy_adr1_timeout", (cyc >= TIMEOUT), 0);
        checkOutput("busy_adr2_byte", (wdLog.size() >= 2) ? wdLog[1] : 8'hXX, 8'hAB);
        checkOutput("busy_adr1_byte", oSpiWd, 8'hCD);
        checkOutput("busy_still", oBusy, 1);
        #2 iSRST = 1'b0;
        #1;
        checkOutput("arst_cs",   oSpiCs, 1);
        checkOutput("arst_en",   oSpiEn, 0);
        checkOutput("arst_busy", oBusy,  0);
        checkOutput("arst_own",  oOwn,   0);
        repeat (3) tick();
        iSRST = 1'b1;
        repeat (3) tick();
        checkOutput("post_rst_idle", oBusy, 0);

        // Back-to-back: restart in the oDone cycle, CS must still stay high long enough.
        $display("[TB] back-to-back starts");
        wdLog.delete();
        d0 = doneCnt;
        pulseStart(24'h000010, 16'd1);
        for (cyc = 0; cyc < TIMEOUT && !oDone; cyc++) tick();
        checkOutput("b2b_first_timeout", (cyc >= TIMEOUT), 0);
        iAdrs  = 24'h000020;
        iLen   = 16'd1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        checkOutput("b2b_accepted", oBusy, 1);
        tick();
        for (cyc = 0; cyc < TIMEOUT && !oDone; cyc++) tick();
        checkOutput("b2b_second_timeout", (cyc >= TIMEOUT), 0);
        repeat (2) tick();
        checkOutput("b2b_cs_gap", (lastHighGap >= GUARD), 1);
        checkOutput("b2b_done_count", doneCnt - d0, 2);
        checkOutput("b2b_wd_count", wdLog.size(), 10);
        checkOutput("b2b_second_cmd", (wdLog.size() >= 10) ? wdLog[5] : 8'hXX, 8'h03);
        checkOutput("b2b_second_adr0", (wdLog.size() >= 10) ? wdLog[8] : 8'hXX, 8'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
